alu_pipe_proc: RTL
==================

// Module: alu_pipe_proc
// PURPOSE
//  Parametrised, registered successor of the processor's 2-bit-op 8-bit ALU.
//  WIDTH-bit operands, 3-bit opcode: logic, add/sub, shift, and an iterative multiply.
//  valid/ready handshakes on both sides; result plus flags held in an output register.
//  Sits between the register-file read stage and the register-file write-back stage.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; WIDTH >= 2; SHW = $clog2(WIDTH)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  op         in   3      opcode, sampled on accept
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept this cycle
//  out        out  WIDTH  result register
//  flags      out  3      {neg, carry, zero}, registered with out
//  out_valid  out  1      out/flags valid
//  out_ready  in   1      consumer takes result
//  write_reg  out  1      = out_valid & out_ready (register-file write strobe, combinational)
// BEHAVIOUR
//  Reset: state=IDLE; out=0, flags=0, out_valid=0, write_reg=0; any in-flight op is discarded.
//  Accept = in_valid & in_ready at a rising edge.
//  in_ready = (state==IDLE) & (~out_valid | out_ready); it is low in BUSY.
//  Opcodes (unsigned, results truncated to WIDTH):
//    000 AND   001 OR   010 XOR   011 NOT in1
//    100 ADD in1+in2, carry = bit WIDTH of the sum
//    101 SUB in1-in2, carry = borrow (in1<in2)
//    110 SHR in1 >> in2[SHW-1:0], logical; carry=0
//    111 MUL low WIDTH bits of in1*in2; carry = (high WIDTH bits != 0)
//  Logic ops: carry=0. All ops: zero=(result==0), neg=result[WIDTH-1].
//  FSM: IDLE, BUSY.
//    IDLE: accept of op!=111 -> out/flags/out_valid loaded on the accept edge (latency 1).
//    IDLE: accept of op 111 -> latch operands, cnt=0, state -> BUSY.
//    BUSY: one shift-add step per edge over a 2*WIDTH accumulator, cnt++.
//    BUSY: on the step where cnt==WIDTH-1, load out/flags, set out_valid, state -> IDLE.
//    MUL latency is WIDTH+1 edges, counting the accept edge.
//  Output register: while out_valid & ~out_ready, out/flags stay stable and nothing new is accepted.
//  Handover: out_valid & out_ready & accept on the same edge loads the new result.
//    For a single-cycle op, out_valid stays 1 (back-to-back throughput 1/cycle).
//    For MUL, out_valid falls to 0 until the multiply completes.
//  out_valid & out_ready with no new result -> out_valid=0; out/flags keep their last value.
//  rst has priority over every other event, including mid-MUL and during a held result.
//  Undefined op bits cannot occur: all 8 opcodes are defined.
// CONFIGURATION
//  ALU_FLAGS_EN defined: flags computed as above.
//  ALU_FLAGS_EN undefined: flags tied to 3'b000, flag logic removed; out/timing unchanged.
// TESTING  (WIDTH=8, ALU_FLAGS_EN defined unless stated)
//  ADD 0xF0+0x20, out_ready=1 -> next edge out=0x10, flags=3'b010, out_valid=1, write_reg=1.
//  SUB 0x05-0x05 then NOT 0x5A back-to-back ->
//    out=0x00 flags=3'b001, then out=0xA5 flags=3'b100; in_ready high both cycles.
//  MUL 0x0D*0x0B -> in_ready=0 for 8 cycles; out_valid rises 9 edges after accept;
//    out=0x8F, flags=3'b100. MUL 0x10*0x10 -> out=0x00, flags=3'b011.
//  Backpressure: ADD result with out_ready=0 for 3 cycles ->
//    out stable, in_ready=0, write_reg=0; out_ready=1 -> one write_reg pulse.
//  rst pulsed 4 cycles into a MUL -> next edge out_valid=0, out=0, state IDLE,
//    in_ready=1; no write_reg pulse ever appears for the aborted op.
//  ALU_FLAGS_EN undefined, ADD 0xFF+0x01 -> out=0x00, flags=3'b000.

Source files
------------

// File: rtl/alu_pipe_proc.sv
// alu_pipe_proc: registered WIDTH-bit ALU with valid/ready handshakes on both
// sides. Logic, add/sub and shift ops finish one edge after accept. MUL uses
// shift-add over WIDTH steps, so it finishes WIDTH+1 edges after accept.
// The result and flags {neg, carry, zero} are held until the consumer takes them.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   op, in1, in2          opcode and operands, sampled on accept
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   out, flags            result register and its flags
//   out_valid / out_ready result handshake
//   write_reg             out_valid & out_ready, the register-file write strobe
//
// Configuration: define ALU_FLAGS_EN to compute flags. If it is not defined,
// flags is tied to 3'b000.
module alu_pipe_proc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic [2:0]       flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             write_reg
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned PW  = 2 * WIDTH;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] out_n;
   logic             out_valid_n;
   logic [WIDTH-1:0] ma, ma_n, mb, mb_n;
   logic [PW-1:0]    acc, acc_n, acc_step;
   logic [SHW-1:0]   cnt, cnt_n;
   logic [WIDTH-1:0] alu_res, ld_res;
   logic             accept, mul_last, load_c;

   assign in_ready  = (state == IDLE) & (~out_valid | out_ready);
   assign write_reg = out_valid & out_ready;
   assign accept    = in_valid & in_ready;
   assign mul_last  = (state == BUSY) & (cnt == SHW'(WIDTH - 1));
   assign load_c    = ((state == IDLE) & accept & (op != OP_MUL)) | mul_last;

   // Shift-add step: add in the multiplicand at bit position cnt if the multiplier bit is set.
   assign acc_step = acc + (mb[cnt] ? (PW'(ma) << cnt) : PW'(0));

   // Single-cycle result. MUL never uses this path.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_AND:  alu_res = in1 & in2;
         OP_OR:   alu_res = in1 | in2;
         OP_XOR:  alu_res = in1 ^ in2;
         OP_NOT:  alu_res = ~in1;
         OP_ADD:  alu_res = in1 + in2;
         OP_SUB:  alu_res = in1 - in2;
         OP_SHR:  alu_res = in1 >> in2[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   assign ld_res = (state == BUSY) ? acc_step[WIDTH-1:0] : alu_res;

`ifdef ALU_FLAGS_EN
   logic [WIDTH:0] sum_c;
   logic           alu_carry, ld_carry;
   logic [2:0]     flags_n;

   assign sum_c = (WIDTH + 1)'(in1) + (WIDTH + 1)'(in2);

   // Carry: add carry-out, subtract borrow, multiply high-half non-zero, otherwise 0.
   always_comb begin
      alu_carry = 1'b0;
      case (op)
         OP_ADD:  alu_carry = sum_c[WIDTH];
         OP_SUB:  alu_carry = (in1 < in2);
         default: alu_carry = 1'b0;
      endcase
   end

   assign ld_carry = (state == BUSY) ? (|acc_step[PW-1:WIDTH]) : alu_carry;
   assign flags_n  = load_c ? {ld_res[WIDTH-1], ld_carry, (ld_res == '0)} : flags;
`else
   assign flags = 3'b000;
`endif

   // Next-state and datapath update.
   always_comb begin
      state_n     = state;
      out_valid_n = out_valid;
      ma_n        = ma;
      mb_n        = mb;
      acc_n       = acc;
      cnt_n       = cnt;
      out_n       = load_c ? ld_res : out;
      if (write_reg) out_valid_n = 1'b0;
      if (load_c) out_valid_n = 1'b1;
      if (state == IDLE) begin
         if (accept && (op == OP_MUL)) begin
            ma_n    = in1;
            mb_n    = in2;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = BUSY;
         end
      end else begin
         acc_n = acc_step;
         cnt_n = cnt + SHW'(1);
         if (mul_last) state_n = IDLE;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         ma        <= '0;
         mb        <= '0;
         acc       <= '0;
         cnt       <= '0;
`ifdef ALU_FLAGS_EN
         flags     <= 3'b000;
`endif
      end else begin
         state     <= state_n;
         out       <= out_n;
         out_valid <= out_valid_n;
         ma        <= ma_n;
         mb        <= mb_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
`ifdef ALU_FLAGS_EN
         flags     <= flags_n;
`endif
      end
   end

endmodule
